uart_rx: RTL and testbench
==========================

# uart_rx

Asynchronous serial receiver: 8 data bits, no parity, 1 stop bit, LSB first, line idle high. It shares the watch's baud-tick generator with the UART transmit path and recovers bytes from the PC/terminal RX pin. Each byte is delivered as a registered 8-bit word with a one-cycle done strobe, plus a framing-error flag for the command decoder downstream.

## Interface
- `OVERSAMPLE`, 8: number of `baud_tick` pulses per bit period; must be even and ≥ 4.
- `clk`  in  1  system clock; every register is clocked on its rising edge.
- `rst`  in  1  synchronous reset, active-low; sampled on the `clk` rising edge.
- `baud_tick`  in  1  one-`clk`-wide pulse at `OVERSAMPLE` × baud rate.
- `rx`  in  1  asynchronous serial line input.
- `o_rx_data`  out  8  last correctly framed byte; holds its value until the next good frame.
- `o_rx_done`  out  1  one-cycle pulse when `o_rx_data` is updated.
- `o_rx_busy`  out  1  high while a frame is in progress (START, DATA or STOP state).
- `o_frame_err`  out  1  high after a frame whose stop bit sampled 0; stays high until the next frame completes.

## Operation
- Input conditioning: `rx` passes through a 2-flop synchronizer to give `rx_s`. A third flop holds `rx_prev`. All three reset to 1.
- Start condition: `rx_prev == 1 && rx_s == 0` (a falling edge). A line held low does not retrigger.
- Counters:
  - `tick_cnt`, width clog2(`OVERSAMPLE`), advances only on cycles with `baud_tick`.
  - `bit_cnt`, 3 bits.
  - `shift_reg`, 8 bits.
- IDLE:
  - `tick_cnt = 0`, `bit_cnt = 0`, busy low.
  - On a falling edge: go to START and set busy high. No `baud_tick` is required.
- START: on each tick, check `tick_cnt == OVERSAMPLE/2 - 1` (mid start bit).
  - If `rx_s == 0`: go to DATA with `tick_cnt = 0` and `bit_cnt = 0`.
  - If `rx_s == 1` (false start): go to IDLE, set busy low, no done, no error change.
  - Otherwise: `tick_cnt++`.
- DATA: on each tick, check `tick_cnt == OVERSAMPLE - 1`.
  - If true: `shift_reg <= {rx_s, shift_reg[7:1]}`, `tick_cnt = 0`, `bit_cnt++`. After bit 7 (`bit_cnt == 7`), go to STOP.
  - Otherwise: `tick_cnt++`.
- STOP: on each tick, check `tick_cnt == OVERSAMPLE - 1`.
  - If `rx_s == 1`: `o_rx_data <= shift_reg`, pulse `o_rx_done`, clear `o_frame_err`.
  - If `rx_s == 0`: set `o_frame_err`; `o_rx_data` is unchanged and no done pulse.
  - In both cases go to IDLE and set busy low.
- A falling edge seen outside IDLE is ignored.
- Back-to-back frames are accepted: a start edge one cycle after returning to IDLE begins the next frame.

## Timing
- Reset values: `o_rx_data = 8'h00`, `o_rx_done = 0`, `o_rx_busy = 0`, `o_frame_err = 0`, state IDLE, all counters 0, synchronizer flops 1.
- Reset asserted mid-frame aborts the frame on that clock edge: no done pulse, `o_rx_data` returns to 0.
- Edge-detect latency: a pin falling edge raises `o_rx_busy` 3 `clk` edges later (2 synchronizer edges plus the IDLE→START edge).
- Sample points, counted in ticks after START entry:
  - start check at tick `OVERSAMPLE/2`;
  - data bit n at tick `OVERSAMPLE/2 + (n+1)·OVERSAMPLE`;
  - stop bit at tick `OVERSAMPLE/2 + 9·OVERSAMPLE` (tick 76 for the default).
- `o_rx_done`, the `o_rx_data` update, `o_frame_err` and busy-low all take effect together on the `clk` edge that consumes the stop-sample tick.
- `o_rx_done` is high for exactly one cycle, and never in two consecutive cycles.
- A `baud_tick` pulse longer than one cycle counts once per high cycle. The tick source must guarantee one-cycle pulses.
- Tolerance: the stop sample stays within its bit for a baud mismatch up to ±(`OVERSAMPLE/2`)/(9.5·`OVERSAMPLE`) ≈ ±5 %.

## Test plan
- Tick every 16 clk. Send 0x55, then 0xA3 with no idle gap between frames. Required: two done pulses; `o_rx_data` = 0x55, then 0xA3; `o_frame_err = 0`; busy low between the frames for at most 1 bit time.
- Send 0x00 and 0xFF. Required: data = 0x00, then 0xFF; done pulse at tick 76 after START entry (±1 tick).
- Glitch: `rx` low for 2 ticks, then high. Required: busy pulses high, then returns to IDLE at tick 4; no done; `o_rx_data` and `o_frame_err` unchanged.
- Framing error: send 0x3C with stop bit = 0, hold `rx` low 20 ticks, then send 0x81 with a valid stop bit.
  - During the low hold: `o_frame_err = 1`, no done, `o_rx_data` unchanged, no retrigger while the line stays low.
  - After 0x81: done pulses, data = 0x81, `o_frame_err` clears.
- Reset mid-frame: assert `rst = 0` for 1 cycle during bit 4 of 0xC7. Required: all outputs return to reset values on that edge; the remainder of the frame produces no done; the next clean frame 0x12 is received correctly.
- Baud skew: send 0x96 with the bit period ±4 % off nominal. Required: data = 0x96, no framing error.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, idle-high line, oversampled by a shared baud tick.
// Delivers each good byte with a one-cycle strobe and flags frames whose stop bit is low.
module uart_rx #(
  parameter int OVERSAMPLE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       rx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_done,
  output logic       o_rx_busy,
  output logic       o_frame_err,
  output logic [1:0] dbg_state
);

  localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            rx_meta;
  logic            rx_s;
  logic            rx_prev;
  logic [TW-1:0]   tick_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift_reg;
  logic            fall_edge;
  logic            half_hit;
  logic            full_hit;
  logic            stop_good;
  logic            stop_bad;

  assign fall_edge = rx_prev & ~rx_s;
  assign half_hit  = baud_tick && (tick_cnt == HALF_LAST);
  assign full_hit  = baud_tick && (tick_cnt == BIT_LAST);

  // Handshake: o_rx_done is a one-cycle valid strobe with no ready; o_rx_data is
  // valid in that cycle and held until the next good frame overwrites it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      rx_prev     <= 1'b1;
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= 3'd0;
      shift_reg   <= 8'h00;
      o_rx_data   <= 8'h00;
      o_rx_done   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_s      <= rx_meta;
      rx_prev   <= rx_s;
      state     <= state_nxt;
      o_rx_done <= stop_good;
      if (stop_good) begin
        o_rx_data   <= shift_reg;
        o_frame_err <= 1'b0;
      end
      if (stop_bad) begin
        o_frame_err <= 1'b1;
      end
      case (state)
        IDLE: begin
          tick_cnt <= '0;
          bit_cnt  <= 3'd0;
        end
        START: begin
          if (half_hit) begin
            tick_cnt <= '0;
            bit_cnt  <= 3'd0;
          end else if (baud_tick) begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        DATA: begin
          if (full_hit) begin
            shift_reg <= {rx_s, shift_reg[7:1]};
            tick_cnt  <= '0;
            bit_cnt   <= bit_cnt + 3'd1;
          end else if (baud_tick) begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        STOP: begin
          if (full_hit) begin
            tick_cnt <= '0;
          end else if (baud_tick) begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        default: begin
          tick_cnt <= '0;
        end
      endcase
    end
  end

  // Edges seen outside IDLE are ignored; a held-low line never re-arms the start.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fall_edge) state_nxt = START;
      START:   if (half_hit) state_nxt = rx_s ? IDLE : DATA;
      DATA:    if (full_hit && (bit_cnt == 3'd7)) state_nxt = STOP;
      STOP:    if (full_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_rx_busy = (state != IDLE);
    dbg_state = state;
    stop_good = (state == STOP) && full_hit && rx_s;
    stop_bad  = (state == STOP) && full_hit && !rx_s;
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are bit-banged on rx against a 1-in-16 baud tick,
// and a negedge monitor records done pulses, tick positions and busy activity.
module tb_uart_rx;

  logic       clk;
  logic       rst;
  logic       baud_tick;
  logic       rx;
  logic [7:0] o_rx_data;
  logic       o_rx_done;
  logic       o_rx_busy;
  logic       o_frame_err;
  logic [1:0] dbg_state;

  int n_vec;
  int n_err;
  int done_cnt;
  int busy_rise_cnt;
  int dbl_done;
  int done_tick;
  int fall_tick;
  int tick_since;
  int low_run;
  int last_low_run;
  int latency;
  int div_cnt;
  logic done_prev;
  logic busy_prev;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  uart_rx #(.OVERSAMPLE(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .baud_tick   (baud_tick),
    .rx          (rx),
    .o_rx_data   (o_rx_data),
    .o_rx_done   (o_rx_done),
    .o_rx_busy   (o_rx_busy),
    .o_frame_err (o_frame_err),
    .dbg_state   (dbg_state)
  );

  // Clock, reset defaults and the baud tick (one pulse every 16 clk).
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    baud_tick = 1'b0;
    div_cnt   = 0;
    forever begin
      @(posedge clk);
      #1;
      baud_tick = (div_cnt == 15);
      div_cnt   = (div_cnt == 15) ? 0 : div_cnt + 1;
    end
  end

  // Monitor: tick_since counts ticks consumed since the edge that entered START.
  initial begin
    done_cnt = 0; busy_rise_cnt = 0; dbl_done = 0; done_tick = -1; fall_tick = -1;
    tick_since = 0; low_run = 0; last_low_run = 0; done_prev = 1'b0; busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (o_rx_done) begin
        done_cnt++;
        got_q.push_back(o_rx_data);
        done_tick = tick_since;
        if (done_prev) dbl_done++;
      end
      if (o_rx_busy && !busy_prev) begin
        busy_rise_cnt++;
        last_low_run = low_run;
        tick_since   = 0;
      end
      if (!o_rx_busy && busy_prev) fall_tick = tick_since;
      low_run    = o_rx_busy ? 0 : low_run + 1;
      tick_since = tick_since + (baud_tick ? 1 : 0);
      done_prev  = o_rx_done;
      busy_prev  = o_rx_busy;
    end
  end

  // Driver tasks: inputs change 1 ns after the rising edge.
  task automatic realign();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) realign();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int bit_clks);
    logic [9:0] bits;
    bits    = {stop_bit, d, 1'b0};
    latency = -1;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      for (int c = 0; c < bit_clks; c++) begin
        @(negedge clk);
        if (i == 0 && latency < 0 && o_rx_busy) latency = c;
        realign();
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rx  = 1'b1;
    repeat (5) realign();
    @(negedge clk);
    n_vec++; if (o_rx_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", o_rx_data); end
    n_vec++; if (o_rx_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", o_rx_done); end
    n_vec++; if (o_rx_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", o_rx_busy); end
    n_vec++; if (o_frame_err !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %b want 0", o_frame_err); end
    n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    realign();
    rst = 1'b1;
    idle(20);
  endtask

  task automatic test_back_to_back();
    int dc;
    int br;
    int lat1;
    dc = done_cnt;
    br = busy_rise_cnt;
    got_q.delete();
    exp_q = {8'h55, 8'hA3};
    send_frame(8'h55, 1'b1, 128);
    lat1 = latency;
    send_frame(8'hA3, 1'b1, 128);
    idle(64);
    @(negedge clk);
    n_vec++; if (lat1 != 3) begin n_err++; $display("FAIL b2b_latency: got %0d want 3", lat1); end
    n_vec++; if (done_cnt - dc != 2) begin n_err++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt - dc); end
    n_vec++; if (busy_rise_cnt - br != 2) begin n_err++; $display("FAIL b2b_busy_rises: got %0d want 2", busy_rise_cnt - br); end
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (got_q.size() <= i) begin n_err++; $display("FAIL b2b_data%0d: got none want %h", i, exp_q[i]); end
      else if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_data%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_vec++; if (o_rx_data !== 8'hA3) begin n_err++; $display("FAIL b2b_hold: got %h want a3", o_rx_data); end
    n_vec++; if (o_frame_err !== 1'b0) begin n_err++; $display("FAIL b2b_ferr: got %b want 0", o_frame_err); end
    n_vec++; if (last_low_run > 128 || last_low_run < 1) begin n_err++; $display("FAIL b2b_gap: got %0d clk want 1..128", last_low_run); end
    realign();
  endtask

  task automatic test_extremes();
    logic [7:0] vals [2];
    vals[0] = 8'h00;
    vals[1] = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      got_q.delete();
      done_tick = -1;
      send_frame(vals[i], 1'b1, 128);
      idle(32);
      @(negedge clk);
      n_vec++;
      if (got_q.size() != 1) begin n_err++; $display("FAIL ext_count%0d: got %0d want 1", i, got_q.size()); end
      else if (got_q[0] !== vals[i]) begin n_err++; $display("FAIL ext_data%0d: got %h want %h", i, got_q[0], vals[i]); end
      n_vec++; if (done_tick < 75 || done_tick > 77) begin n_err++; $display("FAIL ext_tick%0d: got %0d want 76", i, done_tick); end
      realign();
    end
  endtask

  task automatic test_glitch();
    int dc;
    int br;
    dc = done_cnt;
    br = busy_rise_cnt;
    fall_tick = -1;
    rx = 1'b0;
    repeat (32) realign();
    idle(200);
    @(negedge clk);
    n_vec++; if (busy_rise_cnt - br != 1) begin n_err++; $display("FAIL glitch_busy_rise: got %0d want 1", busy_rise_cnt - br); end
    n_vec++; if (fall_tick != 4) begin n_err++; $display("FAIL glitch_idle_tick: got %0d want 4", fall_tick); end
    n_vec++; if (done_cnt != dc) begin n_err++; $display("FAIL glitch_done: got %0d want %0d", done_cnt, dc); end
    n_vec++; if (o_rx_data !== 8'hFF) begin n_err++; $display("FAIL glitch_data: got %h want ff", o_rx_data); end
    n_vec++; if (o_frame_err !== 1'b0) begin n_err++; $display("FAIL glitch_ferr: got %b want 0", o_frame_err); end
    n_vec++; if (o_rx_busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy: got %b want 0", o_rx_busy); end
    realign();
  endtask

  task automatic test_framing();
    int dc;
    int br;
    dc = done_cnt;
    send_frame(8'h3C, 1'b0, 128);
    br = busy_rise_cnt;
    @(negedge clk);
    n_vec++; if (o_frame_err !== 1'b1) begin n_err++; $display("FAIL ferr_set: got %b want 1", o_frame_err); end
    n_vec++; if (o_rx_data !== 8'hFF) begin n_err++; $display("FAIL ferr_data: got %h want ff", o_rx_data); end
    n_vec++; if (done_cnt != dc) begin n_err++; $display("FAIL ferr_done: got %0d want %0d", done_cnt, dc); end
    realign();
    rx = 1'b0;
    repeat (320) realign();
    @(negedge clk);
    n_vec++; if (busy_rise_cnt != br) begin n_err++; $display("FAIL ferr_retrigger: got %0d rises want 0", busy_rise_cnt - br); end
    n_vec++; if (o_frame_err !== 1'b1) begin n_err++; $display("FAIL ferr_hold: got %b want 1", o_frame_err); end
    n_vec++; if (done_cnt != dc) begin n_err++; $display("FAIL ferr_hold_done: got %0d want %0d", done_cnt, dc); end
    realign();
    idle(128);
    got_q.delete();
    send_frame(8'h81, 1'b1, 128);
    idle(32);
    @(negedge clk);
    n_vec++;
    if (got_q.size() != 1) begin n_err++; $display("FAIL ferr_recover_count: got %0d want 1", got_q.size()); end
    else if (got_q[0] !== 8'h81) begin n_err++; $display("FAIL ferr_recover_data: got %h want 81", got_q[0]); end
    n_vec++; if (o_frame_err !== 1'b0) begin n_err++; $display("FAIL ferr_clear: got %b want 0", o_frame_err); end
    realign();
  endtask

  task automatic test_reset_mid();
    logic [9:0] bits;
    int dc;
    bit went_idle;
    bits = {1'b1, 8'hC7, 1'b0};
    dc = done_cnt;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      for (int c = 0; c < 128; c++) begin
        if (i == 5 && c == 32) begin
          rst = 1'b0;
          realign();
          rst = 1'b1;
          @(negedge clk);
          n_vec++; if (o_rx_data !== 8'h00) begin n_err++; $display("FAIL rstmid_data: got %h want 00", o_rx_data); end
          n_vec++; if (o_rx_busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", o_rx_busy); end
          n_vec++; if (o_rx_done !== 1'b0) begin n_err++; $display("FAIL rstmid_done: got %b want 0", o_rx_done); end
          n_vec++; if (o_frame_err !== 1'b0) begin n_err++; $display("FAIL rstmid_ferr: got %b want 0", o_frame_err); end
          n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL rstmid_state: got %0d want 0", dbg_state); end
        end
        realign();
      end
    end
    @(negedge clk);
    n_vec++; if (done_cnt != dc) begin n_err++; $display("FAIL rstmid_no_done: got %0d want %0d", done_cnt, dc); end
    // The line is still low as reset releases, which reads as a fresh start edge;
    // let that phantom frame run out before the clean frame.
    went_idle = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (!o_rx_busy) begin
        went_idle = 1'b1;
        break;
      end
    end
    n_vec++; if (!went_idle) begin n_err++; $display("FAIL rstmid_idle_timeout: got busy want idle"); end
    realign();
    idle(200);
    got_q.delete();
    dc = done_cnt;
    send_frame(8'h12, 1'b1, 128);
    idle(32);
    @(negedge clk);
    n_vec++; if (done_cnt - dc != 1) begin n_err++; $display("FAIL rstmid_next_count: got %0d want 1", done_cnt - dc); end
    n_vec++;
    if (got_q.size() < 1) begin n_err++; $display("FAIL rstmid_next_data: got none want 12"); end
    else if (got_q[0] !== 8'h12) begin n_err++; $display("FAIL rstmid_next_data: got %h want 12", got_q[0]); end
    realign();
  endtask

  task automatic test_skew();
    int periods [2];
    periods[0] = 133;
    periods[1] = 123;
    for (int i = 0; i < 2; i++) begin
      got_q.delete();
      send_frame(8'h96, 1'b1, periods[i]);
      idle(128);
      @(negedge clk);
      n_vec++;
      if (got_q.size() != 1) begin n_err++; $display("FAIL skew%0d_count: got %0d want 1", periods[i], got_q.size()); end
      else if (got_q[0] !== 8'h96) begin n_err++; $display("FAIL skew%0d_data: got %h want 96", periods[i], got_q[0]); end
      n_vec++; if (o_frame_err !== 1'b0) begin n_err++; $display("FAIL skew%0d_ferr: got %b want 0", periods[i], o_frame_err); end
      realign();
    end
  endtask

  task automatic test_done_single();
    n_vec++; if (dbl_done != 0) begin n_err++; $display("FAIL done_width: got %0d double pulses want 0", dbl_done); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b0;
    rx    = 1'b1;
    test_reset();
    test_back_to_back();
    test_extremes();
    test_glitch();
    test_framing();
    test_reset_mid();
    test_skew();
    test_done_single();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
